// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader and the CPU instruction storage it fills.
package prog_loader_pkg;

    localparam int LOADER_BYTE_W = 8;
    localparam int CPU_INSTR_W   = 16;
    localparam int CPU_ADDR_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_timeout_ctr.sv
// Idle-cycle watchdog for the loader: reloads on every accepted byte, counts down while a load waits.
module loader_timeout_ctr #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
            localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= LOAD_VAL;
                end else if (count_en && cnt != '0) begin
                    cnt <= cnt - ONE;
                end
            end

            // Expiry fires on the cycle that would be the TIMEOUT-th idle one.
            assign expired = count_en && (cnt <= ONE);
        end
    endgenerate

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: LEN, N big-endian 16-bit words, XOR checksum; releases the CPU on success.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int WORD_W  = CPU_INSTR_W,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LOADER_BYTE_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     im_wr_en,
    output logic [ADDR_W-1:0]        im_addr,
    output logic [WORD_W-1:0]        im_wr_data,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDR_W:0]          words_loaded
);

    localparam logic [ADDR_W:0]   FULL_N   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    loader_state_t              state;
    logic [LOADER_BYTE_W-1:0]   csum;
    logic [LOADER_BYTE_W-1:0]   word_hi;
    logic [ADDR_W:0]            n_words;
    logic                       xfer;
    logic                       timed_out;

    assign xfer = in_valid && in_ready;

    // The WRITE cycle counts toward the idle budget, so the limit measures time since the last accepted byte.
    loader_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .count_en (busy && !xfer),
        .clear    (xfer || !busy),
        .expired  (timed_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            im_wr_en     <= 1'b0;
            im_addr      <= '0;
            im_wr_data   <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            word_hi      <= '0;
            n_words      <= '0;
        end else begin
            im_wr_en <= 1'b0;
            if (timed_out && state != ST_WRITE) begin
                state    <= ST_ERROR;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                error    <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start) begin
                            state        <= ST_LEN;
                            in_ready     <= 1'b1;
                            busy         <= 1'b1;
                            cpu_hold     <= 1'b1;
                            done         <= 1'b0;
                            error        <= 1'b0;
                            words_loaded <= '0;
                            csum         <= '0;
                            im_addr      <= '0;
                        end
                    end
                    ST_LEN: begin
                        if (xfer) begin
                            n_words <= (in_data == '0) ? FULL_N : (ADDR_W + 1)'(in_data);
                            csum    <= in_data;
                            state   <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        if (xfer) begin
                            word_hi <= in_data;
                            csum    <= csum ^ in_data;
                            state   <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        if (xfer) begin
                            im_wr_data <= {word_hi, in_data};
                            csum       <= csum ^ in_data;
                            im_wr_en   <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        words_loaded <= words_loaded + CNT_ONE;
                        im_addr      <= im_addr + ADDR_ONE;
                        in_ready     <= 1'b1;
                        state        <= (words_loaded + CNT_ONE == n_words) ? ST_CSUM : ST_HI;
                    end
                    ST_CSUM: begin
                        if (xfer) begin
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            if (in_data == csum) begin
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state <= ST_ERROR;
                                error <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
